cdb_writeback_arbiter: RTL

Shares the single common data bus (CDB) between the execution units' completion ports: div, mul, int and ls.
- Each unit's finished result (tag + data) is captured in a small per-unit holding FIFO.
- One result per cycle is broadcast on the CDB, chosen by round-robin.
- Absorbs collisions the issue-side slot reservation cannot prevent (e.g. CDB stall cycles) and back-pressures units via per-unit ready.
- Sits between execution-unit outputs and the reservation-station/ROB CDB snoop logic.

---
 rtl/cdb_writeback_arbiter_if.sv | 44 ++++
 rtl/cdb_writeback_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cdb_writeback_arbiter_if
// Description : Bundle of execution-unit completion ports and the common data
//               bus (CDB) broadcast driven by cdb_writeback_arbiter.
//   unit_valid  [NUM_UNITS]         unit i presents a completed result
//   unit_tag    [NUM_UNITS*TAG_W]   packed tags, unit i at [i*TAG_W +: TAG_W]
//   unit_data   [NUM_UNITS*DATA_W]  packed data, unit i at [i*DATA_W +: DATA_W]
//   unit_ready  [NUM_UNITS]         unit i's holding FIFO can accept
//   flush                           synchronous pipeline flush
//   cdb_stall                       CDB consumers cannot take a broadcast
//   cdb_valid / cdb_tag / cdb_data / cdb_src   registered broadcast
//   master modport : the arbiter; slave modport : units and CDB consumers
// Revision    : 1.0 - initial release
// ============================================================================
interface cdb_writeback_arbiter_if #(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32
);
    localparam int c_src_w = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0]        unit_valid;
    logic [NUM_UNITS*TAG_W-1:0]  unit_tag;
    logic [NUM_UNITS*DATA_W-1:0] unit_data;
    logic [NUM_UNITS-1:0]        unit_ready;
    logic                        flush;
    logic                        cdb_stall;
    logic                        cdb_valid;
    logic [TAG_W-1:0]            cdb_tag;
    logic [DATA_W-1:0]           cdb_data;
    logic [c_src_w-1:0]          cdb_src;

    modport master (
        input  unit_valid, unit_tag, unit_data, flush, cdb_stall,
        output unit_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        output unit_valid, unit_tag, unit_data, flush, cdb_stall,
        input  unit_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface
`default_nettype wire

// File: rtl/cdb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_writeback_arbiter
// Description : Captures each execution unit's completed result (tag + data)
//               in a per-unit holding FIFO and broadcasts one result per cycle
//               on the CDB, choosing among non-empty FIFOs by round-robin.
//               Back-pressures units through unit_ready when a FIFO is full.
// Ports       : clk   - clock, rising edge
//               rst_b - asynchronous active-low reset
//               bus   - cdb_writeback_arbiter_if.master (unit inputs, ready,
//                       flush, cdb_stall, registered CDB broadcast)
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_writeback_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_b,
    cdb_writeback_arbiter_if.master bus
);
    localparam int c_src_w = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ent_w = TAG_W + DATA_W;

    // ---------------------------------------------------------------- state
    logic [c_ent_w-1:0] mem_q    [NUM_UNITS][FIFO_DEPTH];
    logic [c_ent_w-1:0] mem_d    [NUM_UNITS][FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q [NUM_UNITS];
    logic [c_ptr_w-1:0] wr_ptr_d [NUM_UNITS];
    logic [c_ptr_w-1:0] rd_ptr_q [NUM_UNITS];
    logic [c_ptr_w-1:0] rd_ptr_d [NUM_UNITS];
    logic [c_cnt_w-1:0] count_q  [NUM_UNITS];
    logic [c_cnt_w-1:0] count_d  [NUM_UNITS];
    logic [c_src_w-1:0] rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [c_src_w-1:0] cdb_src_q, cdb_src_d;

    // ---------------------------------------------------------- comb wires
    logic [NUM_UNITS-1:0] w_req;
    logic [NUM_UNITS-1:0] w_ready;
    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic                 w_found;
    logic [c_src_w-1:0]   w_winner;
    logic [c_src_w-1:0]   w_rr_next;
    logic [c_ent_w-1:0]   w_head;

    // Wrap an index in [0, 2*NUM_UNITS) back into [0, NUM_UNITS).
    function automatic int wrap_idx(input int a);
        return (a >= NUM_UNITS) ? (a - NUM_UNITS) : a;
    endfunction

    // Readiness is taken from the registered count only, so a full FIFO
    // refuses a push even on a cycle where it is also being popped.
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
        assign w_req[gi]   = (count_q[gi] != '0);
        assign w_ready[gi] = (count_q[gi] < c_cnt_w'(FIFO_DEPTH));
        assign w_push[gi]  = bus.unit_valid[gi] & w_ready[gi] & ~bus.flush;
        assign w_pop[gi]   = w_found & ~bus.cdb_stall & ~bus.flush
                           & (w_winner == c_src_w'(gi));
    end

    assign bus.unit_ready = w_ready;

    // Round-robin search starting at rr_ptr, using FIFO state before this
    // edge's pushes (a result never writes through in the same cycle).
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_found && w_req[wrap_idx(int'(rr_ptr_q) + k)]) begin
                w_found  = 1'b1;
                w_winner = c_src_w'(wrap_idx(int'(rr_ptr_q) + k));
            end
        end
    end

    assign w_rr_next = (w_winner == c_src_w'(NUM_UNITS - 1)) ? '0
                                                              : w_winner + c_src_w'(1);
    assign w_head    = mem_q[w_winner][rd_ptr_q[w_winner]];

    // ------------------------------------------------------ next-state logic
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;

        if (bus.flush) begin
            // Drop everything queued and any same-cycle push; the last
            // broadcast payload is left on the bus.
            for (int i = 0; i < NUM_UNITS; i++) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_ptr_d = '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = {bus.unit_tag[i*TAG_W +: TAG_W],
                                             bus.unit_data[i*DATA_W +: DATA_W]};
                    wr_ptr_d[i] = wr_ptr_q[i] + c_ptr_w'(1);
                end
                if (w_pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + c_ptr_w'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    count_d[i] = count_q[i] + c_cnt_w'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    count_d[i] = count_q[i] - c_cnt_w'(1);
                end
            end

            if (!bus.cdb_stall && w_found) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = w_head[c_ent_w-1 -: TAG_W];
                cdb_data_d  = w_head[DATA_W-1:0];
                cdb_src_d   = w_winner;
                rr_ptr_d    = w_rr_next;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                for (int j = 0; j < FIFO_DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule
`default_nettype wire
